// File: rtl/uart_pkg.sv
// Types and constants shared by the UART transmit path
// (arbiter, transmitter, receiver).
package uart_pkg;

  localparam int UART_DBIT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2
  } arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin priority encoder: first valid index found
// searching upward from last+1, wrapping at NREQ.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] valid,
  input  logic [IW-1:0]   last,
  output logic [IW-1:0]   idx,
  output logic            any
);

  int d;
  int best;

  // d is the rotated distance from last+1; smallest valid d wins
  always_comb begin
    idx  = '0;
    any  = 1'b0;
    best = NREQ;
    d    = 0;
    for (int i = 0; i < NREQ; i++) begin
      d = i - int'(last) - 1;
      if (d < 0) d = d + NREQ;
      if (valid[i] && d < best) begin
        best = d;
        idx  = IW'(i);
        any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter sharing one UART TX FIFO
// between NREQ byte-stream requesters.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int              NREQ     = 4,
  parameter int              DBIT     = uart_pkg::UART_DBIT,
  parameter int              HDR_EN   = 1,
  parameter logic [DBIT-1:0] HDR_BASE = 'hA0,
  parameter int              MAX_LEN  = 16,
  localparam int             IW       = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*DBIT-1:0] req_data,
  input  logic [NREQ-1:0]      req_last,
  output logic [NREQ-1:0]      req_ready,
  output logic [DBIT-1:0]      w_data,
  output logic                 wr_uart,
  input  logic                 tx_full,
  output logic [IW-1:0]        grant_id,
  output logic                 busy,
  output logic                 pkt_trunc
);

  arb_state_e    state_q;
  logic [IW-1:0] last_q;
  logic [IW-1:0] grant_q;
  logic [7:0]    cnt_q;
  logic          trunc_q;

  logic [IW-1:0]   pick_idx;
  logic            pick_any;
  logic [DBIT-1:0] data_a [NREQ];
  logic            g_valid;
  logic            g_last;
  logic            at_max;
  logic            xfer;

  rr_pick #(
    .NREQ (NREQ)
  ) u_pick (
    .valid (req_valid),
    .last  (last_q),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign data_a[g] = req_data[g*DBIT +: DBIT];
  end

  assign g_valid = req_valid[grant_q];
  assign g_last  = req_last[grant_q];
  assign at_max  = (cnt_q == 8'(MAX_LEN - 1));
  assign xfer    = (state_q == DATA) & g_valid & ~tx_full;

  assign grant_id  = grant_q;
  assign busy      = (state_q != IDLE);
  assign pkt_trunc = trunc_q;

  // Write path is combinational so a full FIFO blocks in the same cycle
  always_comb begin
    req_ready = '0;
    wr_uart   = 1'b0;
    w_data    = '0;
    unique case (state_q)
      HDR: begin
        wr_uart = ~tx_full;
        w_data  = HDR_BASE + DBIT'(grant_q);
      end
      DATA: begin
        req_ready[grant_q] = ~tx_full;
        wr_uart            = g_valid & ~tx_full;
        w_data             = data_a[grant_q];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      last_q  <= IW'(NREQ - 1);
      grant_q <= '0;
      cnt_q   <= '0;
      trunc_q <= 1'b0;
    end else begin
      trunc_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (pick_any) begin
            grant_q <= pick_idx;
            cnt_q   <= '0;
            state_q <= (HDR_EN != 0) ? HDR : DATA;
          end
        end
        HDR: begin
          if (!tx_full) state_q <= DATA;
        end
        DATA: begin
          if (xfer) begin
            cnt_q <= cnt_q + 8'd1;
            // remaining bytes of a cut packet re-arbitrate later
            if (g_last || at_max) begin
              last_q  <= grant_q;
              state_q <= IDLE;
              trunc_q <= at_max & ~g_last;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Packet-level round-robin arbiter that shares one UART transmit path (TX FIFO plus transmitter) between NREQ byte-stream requesters.
- Sits between client blocks and the TX FIFO write side: drives the FIFO write strobe and data, and observes the FIFO full flag.
- Optionally prefixes each packet with a requester-ID header byte, and truncates packets longer than MAX_LEN so that no requester can starve the others.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DBIT, 8, data width; must match UART data bits.
- HDR_EN, 1, 1 = emit a header byte HDR_BASE+id before each packet's payload.
- HDR_BASE, 8'hA0, header base value (id added modulo 2^DBIT).
- MAX_LEN, 16, max payload bytes per grant (1..255).

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset; one clock; reset is synchronous and active-low
- req_valid  in  NREQ  requester i presents a byte
- req_data  in  NREQ*DBIT  byte of requester i at [i*DBIT +: DBIT]
- req_last  in  NREQ  byte is final byte of packet
- req_ready  out  NREQ  byte of requester i accepted this cycle when valid&ready
- w_data  out  DBIT  TX FIFO write data
- wr_uart  out  1  TX FIFO write strobe, one byte per high cycle
- tx_full  in  1  TX FIFO full
- grant_id  out  $clog2(NREQ)  current/last granted requester
- busy  out  1  packet in progress (state != IDLE)
- pkt_trunc  out  1  one-cycle pulse when a packet is cut at MAX_LEN

Behaviour:
- Reset (reset_n low at a clk edge): state=IDLE, last_grant=NREQ-1, grant_id=0, byte count=0, pkt_trunc=0. Combinational outputs wr_uart=0, req_ready=0, busy=0 while in IDLE.
- FSM states: IDLE, HDR, DATA.
- IDLE:
  - If any req_valid, pick the first valid index searching (last_grant+1) mod NREQ upward with wrap, and register it into grant_id.
  - Next state is HDR if HDR_EN, else DATA; clear count.
  - No byte is written in the arbitration cycle, so arbitration costs 1 cycle.
- HDR:
  - wr_uart = ~tx_full; w_data = HDR_BASE + grant_id.
  - When written, go to DATA. Stall indefinitely while tx_full.
- DATA:
  - req_ready[grant_id] = ~tx_full; all other ready bits are 0.
  - wr_uart = req_valid[grant_id] & ~tx_full; w_data = req_data of grant_id (combinational pass-through, zero latency).
  - On each transfer, count++.
  - On a transfer with req_last, or with count==MAX_LEN-1: last_grant=grant_id, go to IDLE.
  - If the cut was forced (count==MAX_LEN-1 and req_last=0), pulse pkt_trunc on the next cycle. The requester's remaining bytes form a new packet in a later grant.
- Throughput: one byte per clock while the FIFO is not full and the requester is valid. Back-to-back packets incur 1 idle cycle, plus 1 header cycle if HDR_EN.
- Mid-packet stalls:
  - req_valid dropping mid-packet holds the grant; there is no timeout.
  - tx_full blocks all writes and readies combinationally; wr_uart is never high with tx_full high.
- Requester changes: req_valid of other requesters changing mid-packet has no effect; arbitration only happens in IDLE.
- Single requester: a single requester continuously valid is re-granted every packet.
- Reset mid-packet: FSM returns to IDLE at once. The partial packet already in the FIFO is not recalled; that is the requester's concern.
- grant_id holds its value in IDLE; busy = (state!=IDLE).

Decomposition:
- Shared package uart_pkg: state enum (IDLE/HDR/DATA) and the DBIT default constant, shared with the receiver/transmitter.
- One sub-module, rr_pick: combinational round-robin priority encoder with inputs valid[NREQ] and last[$clog2(NREQ)], and outputs idx and any.
- Everything else lives in uart_tx_arbiter.

Test Plan:
- HDR_EN=1. Req1 sends 3 bytes 11,22,33 (last on 33), tx_full=0 -> FIFO writes A1,11,22,33 on consecutive cycles after 1 arbitration cycle; grant_id=1; busy falls after 33.
- Req0 and req2 both continuously valid with 2-byte packets -> grant order 0,2,0,2; headers A0,A2 alternate; no packet interleaving.
- tx_full held high 5 cycles mid-packet -> wr_uart=0 and req_ready=0 for those 5 cycles; the data byte is held and written on the first cycle tx_full=0; no byte lost or duplicated.
- MAX_LEN=4, req3 sends 6 bytes without last until byte 6 -> 4 bytes written, pkt_trunc pulses once, then a new grant (header A3 again) writes bytes 5,6.
- reset_n low for 1 cycle during DATA of a req0 packet -> next cycle busy=0, wr_uart=0, grant_id=0, last_grant=NREQ-1, so req0 wins next arbitration.
- HDR_EN=0, single requester streaming 1-byte packets -> writes every 2nd cycle with no header bytes.
